// File: rtl/irq_controller_pkg.sv
// rtl/irq_controller_pkg.sv - register offsets, MMIO base and FSM encoding for irq_controller
package irq_controller_pkg;
  localparam logic [31:0] IRQ_BASE    = 32'h0000_3000;
  localparam logic [1:0]  IRQ_MASK    = 2'd0;
  localparam logic [1:0]  IRQ_PENDING = 2'd1;
  localparam logic [1:0]  IRQ_EOI     = 2'd2;
  localparam logic [1:0]  IRQ_CURRENT = 2'd3;
  localparam int          IDX_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;
endpackage

// File: rtl/irq_controller_prio_enc.sv
// rtl/irq_controller_prio_enc.sv - combinational priority encoder, lowest set index wins
module irq_controller_prio_enc
  import irq_controller_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] I_req,
  output logic [IDX_W-1:0]   O_idx,
  output logic               O_any
);
  always_comb begin
    O_idx = '0;
    O_any = |I_req;
    // Scan downwards so the last hit, the lowest index, is the one kept
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (I_req[i]) O_idx = IDX_W'(i);
    end
  end
endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - prioritised interrupt controller: edge capture, request/ack FSM, MMIO registers
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int NUM_W   = 8
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic [NUM_IRQ-1:0] I_irq_src,
  output logic               O_irq_active,
  input  logic               I_irq_ack,
  output logic [NUM_W-1:0]   O_irq_num,
  output logic               O_irq_num_vld,
  input  logic               I_reg_exec,
  input  logic               I_reg_write,
  input  logic [1:0]         I_reg_addr,
  input  logic [15:0]        I_reg_data,
  output logic [15:0]        O_reg_data,
  output logic               O_reg_ready
);
  irq_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] src_q, src_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [NUM_W-1:0]   cur_q, cur_d;
  logic               active_q, active_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic               num_vld_q, num_vld_d;
  logic [15:0]        rdata_q, rdata_d;
  logic               ready_q, ready_d;

  logic [NUM_IRQ-1:0] set_vec, clr_vec;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_any;
  logic               reg_wr, reg_rd;
  logic               unused_wdata;

  assign unused_wdata = ^I_reg_data[15:NUM_IRQ];

  irq_controller_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .I_req (pending_q & mask_q),
    .O_idx (enc_idx),
    .O_any (enc_any)
  );

  always_comb begin
    reg_wr    = I_reg_exec & I_reg_write;
    reg_rd    = I_reg_exec & ~I_reg_write;
    src_d     = I_irq_src;
    set_vec   = I_irq_src & ~src_q;
    clr_vec   = '0;
    state_d   = state_q;
    win_d     = win_q;
    cur_d     = cur_q;
    mask_d    = mask_q;
    num_d     = '0;
    num_vld_d = 1'b0;
    ready_d   = I_reg_exec;
    rdata_d   = '0;

    if (reg_wr && I_reg_addr == IRQ_MASK)    mask_d  = I_reg_data[NUM_IRQ-1:0];
    if (reg_wr && I_reg_addr == IRQ_PENDING) clr_vec = I_reg_data[NUM_IRQ-1:0];

    if (reg_rd) begin
      case (I_reg_addr)
        IRQ_MASK:    rdata_d = 16'(mask_q);
        IRQ_PENDING: rdata_d = 16'(pending_q);
        IRQ_CURRENT: rdata_d = 16'(cur_q);
        default:     rdata_d = '0;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (enc_any) begin
          win_d   = enc_idx;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // win_q is frozen here: delivery ignores later arrivals and software clears
        if (I_irq_ack) begin
          clr_vec   = clr_vec | (NUM_IRQ'(1) << win_q);
          num_d     = NUM_W'(win_q) + NUM_W'(1);
          num_vld_d = 1'b1;
          cur_d     = NUM_W'(win_q) + NUM_W'(1);
          state_d   = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (reg_wr && I_reg_addr == IRQ_EOI) begin
          cur_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    active_d  = (state_d == ST_REQ);
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q   <= ST_IDLE;
      src_q     <= I_irq_src;
      pending_q <= '0;
      mask_q    <= '0;
      win_q     <= '0;
      cur_q     <= '0;
      active_q  <= 1'b0;
      num_q     <= '0;
      num_vld_q <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      win_q     <= win_d;
      cur_q     <= cur_d;
      active_q  <= active_d;
      num_q     <= num_d;
      num_vld_q <= num_vld_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
    end
  end

  assign O_irq_active  = active_q;
  assign O_irq_num     = num_q;
  assign O_irq_num_vld = num_vld_q;
  assign O_reg_data    = rdata_q;
  assign O_reg_ready   = ready_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - self-checking bench for irq_controller
module tb_irq_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src;
  logic        ack, exec, wr;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic        active, vld, ready;
  logic [7:0]  num;
  logic [15:0] rdata;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  irq_controller #(.NUM_IRQ(4), .NUM_W(8)) dut (
    .I_clk        (clk),
    .I_reset      (rst),
    .I_irq_src    (src),
    .O_irq_active (active),
    .I_irq_ack    (ack),
    .O_irq_num    (num),
    .O_irq_num_vld(vld),
    .I_reg_exec   (exec),
    .I_reg_write  (wr),
    .I_reg_addr   (addr),
    .I_reg_data   (wdata),
    .O_reg_data   (rdata),
    .O_reg_ready  (ready)
  );

  // Reference model: pending set, mask, and "requesting"/"in service" flags
  logic [3:0]  m_pend, m_mask, m_prev;
  int          m_win, m_cur, m_num;
  bit          m_req, m_svc, m_vld, m_ready;
  logic [15:0] m_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_update();
    logic [3:0] rise, clr, nmask;
    if (rst) begin
      m_pend = 0; m_mask = 0; m_prev = src; m_req = 0; m_svc = 0;
      m_cur = 0; m_vld = 0; m_num = 0; m_ready = 0; m_rdata = 0;
      return;
    end
    rise = src & ~m_prev; clr = 0; nmask = m_mask;
    m_ready = exec; m_rdata = 0; m_vld = 0; m_num = 0;
    if (exec && !wr) begin
      if (addr == 0) m_rdata = 16'(m_mask);
      else if (addr == 1) m_rdata = 16'(m_pend);
      else if (addr == 3) m_rdata = 16'(m_cur);
    end
    if (exec && wr && addr == 0) nmask = wdata[3:0];
    if (exec && wr && addr == 1) clr = wdata[3:0];
    if (m_req) begin
      if (ack) begin
        clr[m_win] = 1'b1;
        m_vld = 1; m_num = m_win + 1; m_cur = m_win + 1;
        m_req = 0; m_svc = 1;
      end
    end else if (m_svc) begin
      if (exec && wr && addr == 2) begin m_cur = 0; m_svc = 0; end
    end else if ((m_pend & m_mask) != 0) begin
      for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) m_win = i;
      m_req = 1;
    end
    m_pend = (m_pend & ~clr) | rise;
    m_mask = nmask;
    m_prev = src;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    chk("m_active", 32'(active), 32'(m_req));
    chk("m_num_vld", 32'(vld), 32'(m_vld));
    if (m_vld) chk("m_num", 32'(num), 32'(m_num));
    chk("m_reg_ready", 32'(ready), 32'(m_ready));
    chk("m_reg_data", 32'(rdata), 32'(m_rdata));
    ack = 0; exec = 0; wr = 0; addr = 0; wdata = 0;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [15:0] d);
    exec = 1; wr = 1; addr = a; wdata = d;
    cyc();
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [15:0] d);
    exec = 1; wr = 0; addr = a;
    cyc();
    d = rdata;
  endtask

  task automatic pulse_src(input logic [3:0] s);
    src = s; cyc(); src = 0;
  endtask

  task automatic wait_active(input string name);
    for (int k = 0; k < 8 && active !== 1'b1; k++) cyc();
    chk(name, 32'(active), 32'd1);
  endtask

  task automatic ack_expect(input string name, input int vec);
    ack = 1; cyc();
    chk({name, "_vld"}, 32'(vld), 32'd1);
    chk(name, 32'(num), 32'(vec));
  endtask

  typedef struct {
    logic [3:0] src; logic ack, exec, wr; logic [1:0] addr; logic [15:0] data;
    logic e_act, e_vld; logic [7:0] e_num; logic e_rdy; logic [15:0] e_rd;
  } vec_t;
  vec_t tv[8];

  logic [15:0] d;

  initial begin
    tv[0] = '{4'h0, 1'b0, 1'b1, 1'b1, 2'd0, 16'h3, 1'b0, 1'b0, 8'd0, 1'b1, 16'h0};
    tv[1] = '{4'h2, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b0, 16'h0};
    tv[2] = '{4'h0, 1'b0, 1'b1, 1'b0, 2'd1, 16'h0, 1'b1, 1'b0, 8'd0, 1'b1, 16'h2};
    tv[3] = '{4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1, 8'd2, 1'b0, 16'h0};
    tv[4] = '{4'h0, 1'b0, 1'b1, 1'b0, 2'd3, 16'h0, 1'b0, 1'b0, 8'd0, 1'b1, 16'h2};
    tv[5] = '{4'h0, 1'b0, 1'b1, 1'b1, 2'd2, 16'h0, 1'b0, 1'b0, 8'd0, 1'b1, 16'h0};
    tv[6] = '{4'h0, 1'b0, 1'b1, 1'b0, 2'd3, 16'h0, 1'b0, 1'b0, 8'd0, 1'b1, 16'h0};
    tv[7] = '{4'h0, 1'b0, 1'b1, 1'b0, 2'd1, 16'h0, 1'b0, 1'b0, 8'd0, 1'b1, 16'h0};

    rst = 1; src = 0; ack = 0; exec = 0; wr = 0; addr = 0; wdata = 0;
    cyc(); cyc();
    chk("rst_active", 32'(active), 0);
    chk("rst_vld", 32'(vld), 0);
    chk("rst_num", 32'(num), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_rdata", 32'(rdata), 0);
    rst = 0;
    cyc();

    // Basic request/ack/EOI flow from a fixed vector table
    for (int i = 0; i < 8; i++) begin
      src = tv[i].src; ack = tv[i].ack; exec = tv[i].exec; wr = tv[i].wr;
      addr = tv[i].addr; wdata = tv[i].data;
      cyc();
      chk($sformatf("tv%0d_active", i), 32'(active), 32'(tv[i].e_act));
      chk($sformatf("tv%0d_vld", i), 32'(vld), 32'(tv[i].e_vld));
      if (tv[i].e_vld) chk($sformatf("tv%0d_num", i), 32'(num), 32'(tv[i].e_num));
      chk($sformatf("tv%0d_ready", i), 32'(ready), 32'(tv[i].e_rdy));
      chk($sformatf("tv%0d_rdata", i), 32'(rdata), 32'(tv[i].e_rd));
    end

    // Simultaneous edges: lowest index first, the other served after EOI
    reg_wr(2'd0, 16'hF);
    pulse_src(4'h5);
    wait_active("t2_req1");
    ack_expect("t2_vec1", 1);
    reg_wr(2'd2, 0);
    wait_active("t2_req2");
    ack_expect("t2_vec3", 3);
    reg_wr(2'd2, 0);

    // Re-edge in the ack cycle keeps the bit pending
    pulse_src(4'h2);
    wait_active("t3_req");
    src = 4'h2;
    ack_expect("t3_vec2a", 2);
    src = 0;
    reg_rd(2'd1, d);
    chk("t3_pending", 32'(d), 32'h2);
    reg_wr(2'd2, 0);
    wait_active("t3_req2");
    ack_expect("t3_vec2b", 2);
    reg_wr(2'd2, 0);

    // Masked source, unmask, W1C before ack still delivers
    reg_wr(2'd0, 16'h0);
    pulse_src(4'h8);
    cyc(); cyc();
    chk("t4_masked", 32'(active), 0);
    reg_rd(2'd1, d);
    chk("t4_pending", 32'(d), 32'h8);
    reg_wr(2'd0, 16'h8);
    cyc();
    chk("t4_unmask_req", 32'(active), 1);
    reg_wr(2'd1, 16'h8);
    chk("t4_w1c_hold", 32'(active), 1);
    ack_expect("t4_vec4", 4);
    reg_rd(2'd1, d);
    chk("t4_pending_clr", 32'(d), 0);
    reg_wr(2'd2, 0);

    // Source high through reset, then reset while in service
    src = 4'h1; rst = 1; cyc(); cyc(); rst = 0;
    cyc(); cyc();
    chk("t5_no_req", 32'(active), 0);
    reg_rd(2'd1, d);
    chk("t5_no_pend", 32'(d), 0);
    src = 0;
    reg_wr(2'd0, 16'hF);
    pulse_src(4'h4);
    wait_active("t5_req");
    ack_expect("t5_vec3", 3);
    rst = 1; exec = 1; addr = 2'd3;
    cyc();
    chk("t5_rst_active", 32'(active), 0);
    chk("t5_rst_ready", 32'(ready), 0);
    chk("t5_rst_vld", 32'(vld), 0);
    rst = 0;
    reg_rd(2'd3, d);
    chk("t5_cur_clr", 32'(d), 0);
    reg_wr(2'd0, 16'hF);
    pulse_src(4'h4);
    wait_active("t5_req2");
    ack_expect("t5_vec3b", 3);
    reg_wr(2'd2, 0);

    // Stray ack in IDLE, EOI while requesting
    ack = 1; cyc();
    chk("t6_idle_ack_vld", 32'(vld), 0);
    chk("t6_idle_ack_act", 32'(active), 0);
    pulse_src(4'h1);
    wait_active("t6_req");
    reg_wr(2'd2, 0);
    chk("t6_eoi_req_act", 32'(active), 1);
    chk("t6_eoi_ready", 32'(ready), 1);
    ack_expect("t6_vec1", 1);
    reg_rd(2'd3, d);
    chk("t6_cur", 32'(d), 1);
    reg_wr(2'd2, 0);

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) src = 4'($urandom);
      ack   = ($urandom_range(0, 4) == 0);
      exec  = ($urandom_range(0, 2) == 0);
      wr    = 1'($urandom_range(0, 1));
      addr  = 2'($urandom);
      wdata = 16'($urandom);
      cyc();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
